// File: rtl/pipe_pkg.sv
// Shared decode definitions for the 5-stage pipeline hazard logic:
// opcode values, hazard FSM states and the register source/destination decode.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic rd_rs;   // instruction reads rs
    logic rd_rt;   // instruction reads rt
    logic wr;      // instruction writes a register
    logic dst_rd;  // destination is rd (else rt)
  } src_dst_t;

  // Unknown opcodes are treated as reading both rs and rt and writing nothing,
  // so an unrecognised instruction can only over-stall, never miss a hazard.
  function automatic src_dst_t src_dst_decode(input logic [5:0] opcode);
    src_dst_t d;
    d.rd_rs  = 1'b1;
    d.rd_rt  = 1'b1;
    d.wr     = 1'b0;
    d.dst_rd = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d.wr     = 1'b1;
        d.dst_rd = 1'b1;
      end
      OP_LW, OP_ADDI, OP_ANDI, OP_ORI: begin
        d.rd_rt = 1'b0;
        d.wr    = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_scoreboard.sv
// Pending-write scoreboard: one countdown per register, loaded with WB_DIST
// when a writer issues and decremented every unheld cycle. Register 0 is
// never pending.
module scoreboard
  import pipe_pkg::*;
#(
  parameter int WB_DIST = 3,
  parameter int NREG    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [REG_W-1:0] load_idx,
  input  logic [REG_W-1:0] rs_idx,
  input  logic [REG_W-1:0] rt_idx,
  output logic             pend_rs,
  output logic             pend_rt
);

  localparam int CW = $clog2(WB_DIST + 1);

  logic [CW-1:0] cnt [NREG];

  // Countdown update; a load on the same entry wins over its decrement.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst || r == 0) begin
        cnt[r] <= '0;
      end else if (en) begin
        if (load && (int'(load_idx) == r)) begin
          cnt[r] <= CW'(WB_DIST);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  // Two read ports for the IF/ID source registers.
  always_comb begin
    pend_rs = (rs_idx != '0) && (int'(rs_idx) < NREG) && (cnt[rs_idx] != '0);
    pend_rt = (rt_idx != '0) && (int'(rt_idx) < NREG) && (cnt[rt_idx] != '0);
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller for a non-forwarding 5-stage pipeline.
// Stalls the IF/ID instruction while any register it reads has a write in
// flight, and flags a stall that outlives the writeback distance.
// Optional statistics counters are enabled with `define ID_HAZARD_STATS_EN.
module id_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WB_DIST = 3,
  parameter int NREG    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id,
  input  logic        id_valid,
  input  logic        flush,
  input  logic        hold,
  output logic        stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        issue,
`ifdef ID_HAZARD_STATS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] issue_count,
`endif
  output logic        hazard_err
);

  localparam int RLW = $clog2(WB_DIST + 2);

  src_dst_t         dec;
  logic [REG_W-1:0] rs_idx;
  logic [REG_W-1:0] rt_idx;
  logic [REG_W-1:0] dst_idx;
  logic             pend_rs;
  logic             pend_rt;
  logic             hazard;
  logic             load;
  hz_state_e        state;
  hz_state_e        state_nxt;
  logic [RLW-1:0]   run_len;

  assign dec     = src_dst_decode(if_id[31:26]);
  assign rs_idx  = if_id[25:21];
  assign rt_idx  = if_id[20:16];
  assign dst_idx = dec.dst_rd ? if_id[15:11] : if_id[20:16];
  assign hazard  = id_valid & ((dec.rd_rs & pend_rs) | (dec.rd_rt & pend_rt));
  assign load    = issue & dec.wr & (dst_idx != '0);

  scoreboard #(
    .WB_DIST (WB_DIST),
    .NREG    (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (~hold),
    .load     (load),
    .load_idx (dst_idx),
    .rs_idx   (rs_idx),
    .rt_idx   (rt_idx),
    .pend_rs  (pend_rs),
    .pend_rt  (pend_rt)
  );

  // Pipeline control outputs; reset forces a clean, non-stalled front end.
  always_comb begin
    stall       = hazard & ~flush & ~rst;
    issue       = id_valid & ~hazard & ~flush & ~hold & ~rst;
    pc_write    = ~stall & ~hold;
    if_id_write = ~stall & ~hold;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; hold freezes the state.
  always_comb begin
    state_nxt = state;
    if (!hold) begin
      case (state)
        RUN:     if (stall)  state_nxt = STALL;
        STALL:   if (!stall) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Stall run-length and sticky overrun flag; the first stalled cycle is
  // counted on the RUN->STALL transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_len    <= '0;
      hazard_err <= 1'b0;
    end else if (!hold) begin
      case (state)
        RUN: run_len <= stall ? RLW'(1) : '0;
        STALL: begin
          if (!stall) begin
            run_len <= '0;
          end else if (run_len >= RLW'(WB_DIST)) begin
            hazard_err <= 1'b1;
          end else begin
            run_len <= run_len + RLW'(1);
          end
        end
        default: run_len <= '0;
      endcase
    end
  end

`ifdef ID_HAZARD_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (stall && !hold) stall_cycles <= stall_cycles + 32'd1;
      if (issue)          issue_count  <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Table-driven bench for id_hazard_ctrl with an expected-result queue,
// plus hand-written latency and reset-during-stall sequences.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id;
  logic        id_valid;
  logic        flush;
  logic        hold;
  logic        stall;
  logic        pc_write;
  logic        if_id_write;
  logic        issue;
  logic        hazard_err;
`ifdef ID_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] issue_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .if_id       (if_id),
    .id_valid    (id_valid),
    .flush       (flush),
    .hold        (hold),
    .stall       (stall),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .issue       (issue),
`ifdef ID_HAZARD_STATS_EN
    .stall_cycles(stall_cycles),
    .issue_count (issue_count),
`endif
    .hazard_err  (hazard_err)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic        flush;
    logic        hold;
    logic [31:0] ins;
    logic        e_stall;
    logic        e_issue;
    logic        e_pcw;
    logic        e_err;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic add_vec(input logic r, input logic v, input logic f, input logic h,
                         input logic [31:0] ins, input logic st, input logic is,
                         input string name);
    vec_t e;
    e.rst = r; e.valid = v; e.flush = f; e.hold = h; e.ins = ins;
    e.e_stall = st; e.e_issue = is;
    e.e_pcw = ~(st | h);
    e.e_err = 1'b0;
    e.name = name;
    vecs.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic f, input logic h,
                       input logic [31:0] ins);
    rst = r; id_valid = v; flush = f; hold = h; if_id = ins;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] add3, sub4, nop;

  initial begin
    add3 = rtype(1, 2, 3);   // add $3,$1,$2
    sub4 = rtype(3, 5, 4);   // sub $4,$3,$5
    nop  = 32'd0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, nop);

    // Back-to-back dependency
    add_vec(1, 0, 0, 0, nop,  0, 0, "reset");
    add_vec(0, 1, 0, 0, add3, 0, 1, "b2b_add3");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "b2b_stall1");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "b2b_stall2");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "b2b_stall3");
    add_vec(0, 1, 0, 0, sub4, 0, 1, "b2b_issue");
    // $0, no-write instructions, flush
    add_vec(1, 0, 0, 0, nop,  0, 0, "reset2");
    add_vec(0, 1, 0, 0, itype(6'h08, 1, 0, 5), 0, 1, "addi_r0");
    add_vec(0, 1, 0, 0, rtype(0, 0, 2),        0, 1, "read_r0");
    add_vec(0, 1, 0, 0, itype(6'h2B, 1, 6, 0), 0, 1, "sw6");
    add_vec(0, 1, 0, 0, rtype(6, 6, 7),        0, 1, "read_r6");
    add_vec(0, 1, 1, 0, itype(6'h23, 1, 8, 0), 0, 0, "lw8_flush");
    add_vec(0, 1, 0, 0, rtype(8, 8, 9),        0, 1, "read_r8");
    add_vec(0, 1, 1, 0, rtype(9, 0, 11),       0, 0, "hazard_flushed");
    // Hold mid-stall
    add_vec(1, 0, 0, 0, nop,  0, 0, "reset3");
    add_vec(0, 1, 0, 0, add3, 0, 1, "hold_add3");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "hold_stall1");
    add_vec(0, 1, 0, 1, sub4, 1, 0, "hold_held1");
    add_vec(0, 1, 0, 1, sub4, 1, 0, "hold_held2");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "hold_stall2");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "hold_stall3");
    add_vec(0, 1, 0, 0, sub4, 0, 1, "hold_issue");
    add_vec(0, 1, 0, 1, rtype(1, 2, 20),  0, 0, "held_noissue");
    add_vec(0, 1, 0, 0, rtype(20, 0, 21), 0, 1, "held_noload");
    // Same-cycle reload
    add_vec(1, 0, 0, 0, nop,  0, 0, "reset4");
    add_vec(0, 1, 0, 0, add3, 0, 1, "rl_add3");
    add_vec(0, 0, 0, 0, nop,  0, 0, "rl_idle1");
    add_vec(0, 0, 0, 0, nop,  0, 0, "rl_idle2");
    add_vec(0, 1, 0, 0, itype(6'h08, 1, 3, 1), 0, 1, "rl_reload");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "rl_stall1");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "rl_stall2");
    add_vec(0, 1, 0, 0, sub4, 1, 0, "rl_stall3");
    add_vec(0, 1, 0, 0, sub4, 0, 1, "rl_issue");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].flush, vecs[i].hold, vecs[i].ins);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      begin
        vec_t e;
        e = exp_q.pop_front();
        chk({e.name, ".stall"},       32'(stall),       32'(e.e_stall));
        chk({e.name, ".issue"},       32'(issue),       32'(e.e_issue));
        chk({e.name, ".pc_write"},    32'(pc_write),    32'(e.e_pcw));
        chk({e.name, ".if_id_write"}, 32'(if_id_write), 32'(e.e_pcw));
        chk({e.name, ".hazard_err"},  32'(hazard_err),  32'(e.e_err));
      end
      step();
    end

    // Latency measurement with a bounded wait for issue
    begin
      int  nst;
      bit  got;
      nst = 0; got = 0;
      drive(1, 0, 0, 0, nop); step();
      drive(0, 1, 0, 0, add3); step();
      drive(0, 1, 0, 0, sub4);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (issue) begin
          got = 1;
          break;
        end
        if (stall) nst++;
        step();
      end
      chk("lat_issue_seen", 32'(got), 32'd1);
      chk("lat_stall_cycles", 32'(nst), 32'd3);
      step();
    end

    // Reset during a stall
    drive(1, 0, 0, 0, nop); step();
    drive(0, 1, 0, 0, add3);
    @(negedge clk); chk("rms_add3_issue", 32'(issue), 32'd1);
    step();
    drive(0, 1, 0, 0, sub4);
    @(negedge clk); chk("rms_stall", 32'(stall), 32'd1);
    step();
    drive(1, 1, 0, 0, sub4);
    @(negedge clk);
    chk("rms_rst_stall", 32'(stall), 32'd0);
    chk("rms_rst_issue", 32'(issue), 32'd0);
    chk("rms_rst_pcw",   32'(pc_write), 32'd1);
    step();
    drive(0, 1, 0, 0, sub4);
    @(negedge clk);
    chk("rms_after_issue", 32'(issue), 32'd1);
    chk("rms_after_stall", 32'(stall), 32'd0);
    chk("rms_after_err",   32'(hazard_err), 32'd0);
`ifdef ID_HAZARD_STATS_EN
    chk("rms_stall_cycles", stall_cycles, 32'd0);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Scoreboard-based hazard controller for the decode stage of the 5-stage pipeline (IF, ID, EX, MEM, WB). The pipeline has no forwarding.
- It tracks which registers have a write outstanding in flight. It raises `stall` while the instruction in IF/ID reads such a register.
- `stall` drives the decode-stage bubble input, which zeroes the 9-bit control bundle. It also freezes PC and IF/ID until the writeback becomes visible to the register-file read.

Parameters:
- `WB_DIST`, 3: cycles from an instruction leaving ID until its register-file write is readable in ID.
- `NREG`, 32: architectural register count; register 0 is never tracked.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_id`  in  32  instruction currently held in IF/ID.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `flush`  in  1  squash the IF/ID instruction this cycle (taken branch).
- `hold`  in  1  global pipeline freeze (memory not ready).
- `stall`  out  1  bubble request to the decode stage.
- `pc_write`  out  1  PC update enable.
- `if_id_write`  out  1  IF/ID update enable.
- `issue`  out  1  the IF/ID instruction advances to EX this cycle.
- `hazard_err`  out  1  sticky; a stall exceeded `WB_DIST` consecutive cycles.

Behaviour:
- Decode, combinational from `if_id[31:26]`:
  - R-type 000000: reads rs, rt; writes rd[15:11].
  - lw 100011: reads rs; writes rt.
  - sw 101011: reads rs, rt; no write.
  - beq 000100: reads rs, rt; no write.
  - addi 001000, andi 001100, ori 001101: read rs; write rt.
  - Any other opcode: reads rs and rt, no write (conservative).
- Scoreboard: `cnt[r]`, 2-bit for the default `WB_DIST` (width = clog2(`WB_DIST`+1)), for r = 1..`NREG`-1. `cnt[0]` is hard-wired to 0.
- Hazard: `id_valid` and (`cnt[rs]` != 0 for a read rs, or `cnt[rt]` != 0 for a read rt).
- Combinational outputs:
  - `stall` = hazard & ~`flush` & ~`rst`.
  - `issue` = `id_valid` & ~hazard & ~`flush` & ~`hold` & ~`rst`.
  - `pc_write` = `if_id_write` = ~`stall` & ~`hold`.
- Per-clock update when not `hold`:
  - Every nonzero `cnt` decrements by 1.
  - If `issue` and the instruction writes register d != 0, then `cnt[d]` <= `WB_DIST`. This load overrides the decrement of that same entry in the same cycle.
- `hold`: all counters, state and the stall run-length freeze. `issue` = 0. `stall` is still reported.
- `flush`: there is no issue and no scoreboard update from IF/ID; counters still decrement.
- FSM, 2 states:
  - RUN → STALL when `stall` & ~`hold`.
  - STALL → RUN when ~`stall`.
  - In STALL, a run-length counter increments each unheld cycle. If it would exceed `WB_DIST`, `hazard_err` is set and held until `rst`.
  - The run-length counter clears on entry to RUN.
- Reset, one cycle with `rst` high:
  - All `cnt` = 0, state RUN, run-length 0, `hazard_err` 0.
  - Outputs during `rst`: `stall` 0, `issue` 0, `pc_write` 1, `if_id_write` 1.
- Reset mid-stall: all pending entries are discarded and the pipeline is assumed flushed externally.
- Latency: a dependent instruction that reaches ID directly after its producer stalls exactly `WB_DIST` cycles.

Optional Feature:
- Macro `ID_HAZARD_STATS_EN`.
- Defined:
  - Adds outputs `stall_cycles[31:0]` and `issue_count[31:0]`.
  - `stall_cycles` counts cycles with `stall` & ~`hold`; `issue_count` counts `issue` pulses.
  - Both are free-running, wrap at 2^32, and clear on `rst`.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Package `pipe_pkg`:
  - Opcode localparams: `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_ANDI`, `OP_ORI`.
  - FSM state enum {RUN, STALL}.
  - Function `src_dst_decode(opcode)` returning read-rs, read-rt, writes, dest-is-rd.
- Sub-module `scoreboard`: the `cnt` array, decrement and issue-load logic, and the two-port pending lookup (rs, rt). `id_hazard_ctrl` holds the decode, the FSM and the outputs.

Test Plan:
- Back-to-back dependency: issue `add $3,$1,$2`, then `sub $4,$3,$5` in IF/ID next cycle → `stall`=1 for exactly 3 cycles, `pc_write`=`if_id_write`=0, then `issue`=1 on the 4th cycle; `hazard_err` stays 0.
- Register 0 and no-write instructions:
  - `addi $0,$1,5` then `add $2,$0,$0` → no stall.
  - `sw $6,0($1)` then `add $7,$6,$6` → no stall (sw does not mark $6).
- Flush: `lw $8,0($1)` in IF/ID with `flush`=1 → `issue`=0, `cnt[8]` stays 0; next `add $9,$8,$8` → no stall.
- Hold during stall: dependency as in the first case, with `hold`=1 for 2 cycles mid-stall → the stall lasts 3 unheld cycles (5 wall cycles); no `hazard_err`.
- Same-cycle reload: `cnt[3]`=1 while `addi $3,$3,1` … is blocked — instead, issue `add $3,…` when `cnt[3]` reaches 0 in the same cycle another write to $3 issues → `cnt[3]`=3 afterward, not 2.
- Reset mid-stall: `rst` asserted during a 3-cycle stall → all counters 0, `stall` 0, next dependent instruction issues immediately; with `ID_HAZARD_STATS_EN`, `stall_cycles`=0.
